// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer
//
// Write-side feeder for the SDRAM facade. Bytes from the UART receiver are
// packed little-endian into PixelBitWidth-wide pixels and queued in a small
// synchronous FIFO. A three-state drain machine (IDLE -> ISSUE -> GAP) hands
// pixels one at a time to the facade, honouring its write-busy flag. Delivered
// pixels are counted per frame to produce an end-of-frame pulse, and a sticky
// flag records any pixel dropped because the FIFO was full.
//
// Optional build macro:
//   PACKER_TIMEOUT_EN - discard a partially assembled pixel after
//                       TimeoutCycles idle cycles. Without it a partial pixel
//                       waits indefinitely.
//
// Ports:
//   CLK           in   system clock
//   RST           in   asynchronous active-low reset
//   i_byte        in   received UART byte
//   i_byte_valid  in   i_byte valid for this cycle only
//   i_busy_wr     in   facade write side busy
//   o_pixel       out  pixel to the facade (held while o_ready=0)
//   o_ready       out  one-cycle pulse marking o_pixel valid
//   o_fill        out  current FIFO occupancy
//   o_overflow    out  sticky: a pixel was dropped on a full FIFO
//   o_frame_done  out  one-cycle pulse with the last pixel of a frame

module uart_pixel_packer #(
    parameter int FrameWidth    = 640,
    parameter int FrameHeight   = 480,
    parameter int PixelBitWidth = 16,
    parameter int FifoDepth     = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [7:0]                     i_byte,
    input  logic                           i_byte_valid,
    input  logic                           i_busy_wr,
    output logic [PixelBitWidth-1:0]       o_pixel,
    output logic                           o_ready,
    output logic [$clog2(FifoDepth+1)-1:0] o_fill,
    output logic                           o_overflow,
    output logic                           o_frame_done
);

    localparam int BPP       = PixelBitWidth / 8;
    localparam int IDX_W     = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int PTR_W     = $clog2(FifoDepth);
    localparam int FILL_W    = $clog2(FifoDepth + 1);
    localparam int FRAME_PIX = FrameWidth * FrameHeight;
    localparam int FC_W      = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    // Elaboration-time guard on parameter legality.
    if ((PixelBitWidth % 8) != 0 || PixelBitWidth < 8 || FifoDepth < 2 ||
        (FifoDepth & (FifoDepth - 1)) != 0 || TimeoutCycles < 1 || FRAME_PIX < 1) begin : g_param_check
        $error("uart_pixel_packer: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [PixelBitWidth-1:0]   asm_q, asm_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]          fill_q, fill_d;
    logic [FC_W-1:0]            frame_cnt_q, frame_cnt_d;
    logic [PixelBitWidth-1:0]   pixel_q, pixel_d;
    logic                       ready_q, ready_d;
    logic                       overflow_q, overflow_d;
    logic                       frame_done_q, frame_done_d;
    logic [PixelBitWidth-1:0]   mem_q [FifoDepth];

    logic                       last_byte;
    logic                       pop;
    logic                       push;
    logic                       fifo_full;
    logic                       frame_last;

`ifdef PACKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TimeoutCycles + 1);
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        frame_cnt_d  = frame_cnt_q;
        pixel_d      = pixel_q;
        ready_d      = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        // Byte assembly: byte index selects the destination lane, low byte first.
        last_byte = i_byte_valid && (idx_q == IDX_W'(BPP - 1));
        if (i_byte_valid) begin
            for (int b = 0; b < BPP; b++) begin
                if (idx_q == IDX_W'(b)) begin
                    asm_d[b*8 +: 8] = i_byte;
                end
            end
            idx_d = last_byte ? '0 : idx_q + IDX_W'(1);
        end

`ifdef PACKER_TIMEOUT_EN
        // Counter only runs while a pixel is partially assembled and the line
        // is quiet; on expiry the lane index restarts at the low byte.
        to_cnt_d = '0;
        if (idx_q != '0 && !i_byte_valid) begin
            if (to_cnt_q == TO_W'(TimeoutCycles - 1)) begin
                idx_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif

        // A pop on the same edge frees the slot, so a push into a full FIFO
        // is accepted in that case.
        fifo_full = (fill_q == FILL_W'(FifoDepth));
        pop       = (state_q == S_IDLE) && (fill_q != '0) && !i_busy_wr;
        push      = last_byte && (!fifo_full || pop);

        if (last_byte && !push) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - FILL_W'(1);
        end

        frame_last = (frame_cnt_q == FC_W'(FRAME_PIX - 1));

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d      = S_ISSUE;
                    pixel_d      = mem_q[rd_ptr_q];
                    ready_d      = 1'b1;
                    frame_done_d = frame_last;
                    frame_cnt_d  = frame_last ? '0 : frame_cnt_q + FC_W'(1);
                end
            end
            S_ISSUE: begin
                state_d = S_GAP;
            end
            // Quiet cycle so the facade's busy flag is current before the
            // next IDLE decision.
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            frame_cnt_q  <= '0;
            pixel_q      <= '0;
            ready_q      <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef PACKER_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            frame_cnt_q  <= frame_cnt_d;
            pixel_q      <= pixel_d;
            ready_q      <= ready_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
`ifdef PACKER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    // Datapath storage carries no reset; validity is tracked by the
    // byte index and FIFO pointers.
    always_ff @(posedge CLK) begin
        asm_q <= asm_d;
        if (push) begin
            mem_q[wr_ptr_q] <= asm_d;
        end
    end

    assign o_pixel      = pixel_q;
    assign o_ready      = ready_q;
    assign o_fill       = fill_q;
    assign o_overflow   = overflow_q;
    assign o_frame_done = frame_done_q;

endmodule
